// File: rtl/input_channel_buffer_bank.sv
// input_channel_buffer_bank
// This module is a per-PE bank of independent input-channel FIFOs. Each FIFO
// buffers tagged words that arrive from the interconnect. It exposes:
//   - the head word and tag of each channel,
//   - the raw per-channel empty status,
//   - a per-channel "not full" ready signal.
// The decode stage pops channels through the icd mask.
//
// Optional feature: when TIA_INPUT_CHANNEL_COUNT_EN is defined, the module
// also exports the registered per-channel occupancy counts on the
// input_channel_counts port.
//
// Widths come from control.svh. The fallbacks below let this file build on
// its own when that header is not in scope.
`ifndef TIA_NUM_INPUT_CHANNELS
`define TIA_NUM_INPUT_CHANNELS 4
`endif
`ifndef TIA_ICD_WIDTH
`define TIA_ICD_WIDTH `TIA_NUM_INPUT_CHANNELS
`endif
`ifndef TIA_WORD_WIDTH
`define TIA_WORD_WIDTH 32
`endif
`ifndef TIA_TAG_WIDTH
`define TIA_TAG_WIDTH 3
`endif

module input_channel_buffer_bank #(
  parameter int DEPTH = 4
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic [`TIA_NUM_INPUT_CHANNELS-1:0]                  input_channel_valid,
  output logic [`TIA_NUM_INPUT_CHANNELS-1:0]                  input_channel_ready,
  input  logic [`TIA_NUM_INPUT_CHANNELS*`TIA_WORD_WIDTH-1:0]  input_channel_data,
  input  logic [`TIA_NUM_INPUT_CHANNELS*`TIA_TAG_WIDTH-1:0]   input_channel_tags,
  input  logic [`TIA_ICD_WIDTH-1:0]                           icd,
  output logic [`TIA_NUM_INPUT_CHANNELS*`TIA_WORD_WIDTH-1:0]  head_data,
  output logic [`TIA_NUM_INPUT_CHANNELS*`TIA_TAG_WIDTH-1:0]   head_tags,
  output logic [`TIA_NUM_INPUT_CHANNELS-1:0]                  input_channel_empty_status,
  output logic                                                underflow_error
`ifdef TIA_INPUT_CHANNEL_COUNT_EN
  ,
  output logic [`TIA_NUM_INPUT_CHANNELS*($clog2(DEPTH)+1)-1:0] input_channel_counts
`endif
);

  localparam int N     = `TIA_NUM_INPUT_CHANNELS;
  localparam int W     = `TIA_WORD_WIDTH;
  localparam int T     = `TIA_TAG_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage is deliberately left without a reset. The pointers and counts
  // alone decide which entries are live.
  logic [W-1:0]     data_mem [N][DEPTH];
  logic [T-1:0]     tag_mem  [N][DEPTH];

  logic [PTR_W-1:0] head_ptr [N];
  logic [PTR_W-1:0] tail_ptr [N];
  logic [CNT_W-1:0] count    [N];

  logic [N-1:0]     empty;
  logic [N-1:0]     full;
  logic [N-1:0]     push;
  logic [N-1:0]     pop;

  // Per-channel status and handshakes, derived only from registered counts.
  // Because of this, a full channel refuses a push even when it is popped
  // in the same cycle.
  always_comb begin
    empty = '0;
    full  = '0;
    push  = '0;
    pop   = '0;
    for (int i = 0; i < N; i++) begin
      empty[i] = (count[i] == '0);
      full[i]  = (count[i] == CNT_W'(DEPTH));
      push[i]  = input_channel_valid[i] & ~full[i];
      pop[i]   = icd[i] & ~empty[i];
    end
  end

  assign input_channel_ready        = ~full;
  assign input_channel_empty_status = empty;

  // Combinational head read. The value is meaningless while the channel is
  // empty. A word written this cycle only becomes visible after the edge.
  always_comb begin
    head_data = '0;
    head_tags = '0;
    for (int i = 0; i < N; i++) begin
      head_data[i*W +: W] = data_mem[i][head_ptr[i]];
      head_tags[i*T +: T] = tag_mem[i][head_ptr[i]];
    end
  end

  // Write accepted words at the tail slot. A push in the reset cycle is dropped.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (push[i] && !reset) begin
        data_mem[i][tail_ptr[i]] <= input_channel_data[i*W +: W];
        tag_mem[i][tail_ptr[i]]  <= input_channel_tags[i*T +: T];
      end
    end
  end

  // Pointer and occupancy bookkeeping. Pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        head_ptr[i] <= '0;
        tail_ptr[i] <= '0;
        count[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push[i]) tail_ptr[i] <= tail_ptr[i] + PTR_W'(1);
        if (pop[i])  head_ptr[i] <= head_ptr[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Sticky flag for any attempt to pop an empty channel. Only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      underflow_error <= 1'b0;
    end else if (|(icd & empty)) begin
      underflow_error <= 1'b1;
    end
  end

`ifdef TIA_INPUT_CHANNEL_COUNT_EN
  // Pack the registered counts for the count-aware empty-status updaters.
  always_comb begin
    input_channel_counts = '0;
    for (int i = 0; i < N; i++) begin
      input_channel_counts[i*CNT_W +: CNT_W] = count[i];
    end
  end
`endif

endmodule

// File: tb/tb_input_channel_buffer_bank.sv
// tb_input_channel_buffer_bank
// This is a directed testbench for input_channel_buffer_bank with 4 channels
// and DEPTH = 4. It uses a vector table followed by hand-written multi-cycle
// sequences. The count checks are compiled in only when
// TIA_INPUT_CHANNEL_COUNT_EN is defined.
`ifndef TIA_NUM_INPUT_CHANNELS
`define TIA_NUM_INPUT_CHANNELS 4
`endif
`ifndef TIA_ICD_WIDTH
`define TIA_ICD_WIDTH `TIA_NUM_INPUT_CHANNELS
`endif
`ifndef TIA_WORD_WIDTH
`define TIA_WORD_WIDTH 32
`endif
`ifndef TIA_TAG_WIDTH
`define TIA_TAG_WIDTH 3
`endif

module tb_input_channel_buffer_bank;

  localparam int N     = `TIA_NUM_INPUT_CHANNELS;
  localparam int W     = `TIA_WORD_WIDTH;
  localparam int T     = `TIA_TAG_WIDTH;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               clock = 1'b0;
  logic               reset;
  logic [N-1:0]       input_channel_valid;
  logic [N-1:0]       input_channel_ready;
  logic [N*W-1:0]     input_channel_data;
  logic [N*T-1:0]     input_channel_tags;
  logic [N-1:0]       icd;
  logic [N*W-1:0]     head_data;
  logic [N*T-1:0]     head_tags;
  logic [N-1:0]       input_channel_empty_status;
  logic               underflow_error;
`ifdef TIA_INPUT_CHANNEL_COUNT_EN
  logic [N*CNT_W-1:0] input_channel_counts;
`endif

  int checks = 0;
  int fails  = 0;

  input_channel_buffer_bank #(.DEPTH(DEPTH)) dut (
    .clock                      (clock),
    .reset                      (reset),
    .input_channel_valid        (input_channel_valid),
    .input_channel_ready        (input_channel_ready),
    .input_channel_data         (input_channel_data),
    .input_channel_tags         (input_channel_tags),
    .icd                        (icd),
    .head_data                  (head_data),
    .head_tags                  (head_tags),
    .input_channel_empty_status (input_channel_empty_status),
    .underflow_error            (underflow_error)
`ifdef TIA_INPUT_CHANNEL_COUNT_EN
    ,
    .input_channel_counts       (input_channel_counts)
`endif
  );

  always #5 clock = ~clock;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic         rst;
    logic [N-1:0] valid;
    logic [N-1:0] pop;
    int           dch;
    logic [W-1:0] dword;
    logic [T-1:0] dtag;
    logic [N-1:0] exp_empty;
    logic [N-1:0] exp_ready;
    logic         exp_uf;
    int           hch;
    logic [W-1:0] hdata;
    logic [T-1:0] htag;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic rst, logic [N-1:0] valid, logic [N-1:0] pop,
                              int dch, logic [W-1:0] dword, logic [T-1:0] dtag,
                              logic [N-1:0] e, logic [N-1:0] r, logic uf,
                              int hch, logic [W-1:0] hd, logic [T-1:0] ht);
    vec_t v;
    v.rst = rst; v.valid = valid; v.pop = pop; v.dch = dch; v.dword = dword; v.dtag = dtag;
    v.exp_empty = e; v.exp_ready = r; v.exp_uf = uf; v.hch = hch; v.hdata = hd; v.htag = ht;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then wait for the next
  // rising edge plus 1 time unit, so the caller samples post-edge state.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] valid, input logic [N-1:0] pop,
                               input int dch, input logic [W-1:0] dword, input logic [T-1:0] dtag);
    @(negedge clock);
    reset               = rst;
    input_channel_valid = valid;
    icd                 = pop;
    input_channel_data  = '0;
    input_channel_tags  = '0;
    input_channel_data[dch*W +: W] = dword;
    input_channel_tags[dch*T +: T] = dtag;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] headWord(int ch);
    return head_data[ch*W +: W];
  endfunction

  function automatic logic [T-1:0] headTag(int ch);
    return head_tags[ch*T +: T];
  endfunction

  initial begin
    reset = 1'b1;
    input_channel_valid = '0;
    icd = '0;
    input_channel_data = '0;
    input_channel_tags = '0;

    //              rst valid   pop     dch data   tag  empty   ready   uf hch hdata  htag
    vecs[0]  = mk(1, 4'b0000, 4'b0000, 0, 0,     0, 4'b1111, 4'b1111, 0, -1, 0,     0);
    vecs[1]  = mk(0, 4'b0000, 4'b0000, 0, 0,     0, 4'b1111, 4'b1111, 0, -1, 0,     0);
    vecs[2]  = mk(0, 4'b0000, 4'b0000, 0, 0,     0, 4'b1111, 4'b1111, 0, -1, 0,     0);
    vecs[3]  = mk(0, 4'b0001, 4'b0000, 0, 'hA5,  2, 4'b1110, 4'b1111, 0,  0, 'hA5,  2);
    vecs[4]  = mk(0, 4'b0000, 4'b0001, 0, 0,     0, 4'b1111, 4'b1111, 0, -1, 0,     0);
    vecs[5]  = mk(0, 4'b0010, 4'b0000, 1, 1,     1, 4'b1101, 4'b1111, 0,  1, 1,     1);
    vecs[6]  = mk(0, 4'b0010, 4'b0000, 1, 2,     2, 4'b1101, 4'b1111, 0,  1, 1,     1);
    vecs[7]  = mk(0, 4'b0010, 4'b0000, 1, 3,     3, 4'b1101, 4'b1111, 0,  1, 1,     1);
    vecs[8]  = mk(0, 4'b0010, 4'b0000, 1, 4,     4, 4'b1101, 4'b1101, 0,  1, 1,     1);
    vecs[9]  = mk(0, 4'b0010, 4'b0000, 1, 5,     5, 4'b1101, 4'b1101, 0,  1, 1,     1);
    vecs[10] = mk(0, 4'b0000, 4'b0010, 0, 0,     0, 4'b1101, 4'b1111, 0,  1, 2,     2);
    vecs[11] = mk(0, 4'b0000, 4'b0010, 0, 0,     0, 4'b1101, 4'b1111, 0,  1, 3,     3);
    vecs[12] = mk(0, 4'b0000, 4'b0010, 0, 0,     0, 4'b1101, 4'b1111, 0,  1, 4,     4);
    vecs[13] = mk(0, 4'b0000, 4'b0010, 0, 0,     0, 4'b1111, 4'b1111, 0, -1, 0,     0);
    vecs[14] = mk(0, 4'b0100, 4'b0000, 2, 'h10,  5, 4'b1011, 4'b1111, 0,  2, 'h10,  5);
    vecs[15] = mk(0, 4'b0100, 4'b0100, 2, 'h20,  6, 4'b1011, 4'b1111, 0,  2, 'h20,  6);
    vecs[16] = mk(0, 4'b0000, 4'b0100, 0, 0,     0, 4'b1111, 4'b1111, 0, -1, 0,     0);
    vecs[17] = mk(0, 4'b0001, 4'b0000, 0, 'h77,  7, 4'b1110, 4'b1111, 0,  0, 'h77,  7);
    vecs[18] = mk(0, 4'b0000, 4'b1000, 0, 0,     0, 4'b1110, 4'b1111, 1,  0, 'h77,  7);
    vecs[19] = mk(0, 4'b0000, 4'b0000, 0, 0,     0, 4'b1110, 4'b1111, 1,  0, 'h77,  7);
    vecs[20] = mk(0, 4'b0000, 4'b0001, 0, 0,     0, 4'b1111, 4'b1111, 1, -1, 0,     0);
    vecs[21] = mk(1, 4'b0000, 4'b0000, 0, 0,     0, 4'b1111, 4'b1111, 0, -1, 0,     0);

    for (int r = 0; r < 22; r++) begin
      applyStimulus(vecs[r].rst, vecs[r].valid, vecs[r].pop, vecs[r].dch, vecs[r].dword, vecs[r].dtag);
      checkOutput($sformatf("row%0d empty", r), 64'(input_channel_empty_status), 64'(vecs[r].exp_empty));
      checkOutput($sformatf("row%0d ready", r), 64'(input_channel_ready), 64'(vecs[r].exp_ready));
      checkOutput($sformatf("row%0d underflow", r), 64'(underflow_error), 64'(vecs[r].exp_uf));
      if (vecs[r].hch >= 0) begin
        checkOutput($sformatf("row%0d head_data", r), 64'(headWord(vecs[r].hch)), 64'(vecs[r].hdata));
        checkOutput($sformatf("row%0d head_tag", r), 64'(headTag(vecs[r].hch)), 64'(vecs[r].htag));
      end
`ifdef TIA_INPUT_CHANNEL_COUNT_EN
      if (r == 15)
        checkOutput("ch2 count after push+pop", 64'(input_channel_counts[2*CNT_W +: CNT_W]), 64'd1);
`endif
    end

    // Fill ch1, then push and pop together while full. The push must be
    // refused, so three more pops drain the channel.
    for (int k = 0; k < 4; k++) applyStimulus(0, 4'b0010, 4'b0000, 1, W'(11 + k), T'(k));
    checkOutput("ch1 full ready", 64'(input_channel_ready[1]), 64'd0);
    applyStimulus(0, 4'b0010, 4'b0010, 1, W'(15), T'(7));
    checkOutput("full push+pop ready", 64'(input_channel_ready[1]), 64'd1);
    checkOutput("full push+pop head", 64'(headWord(1)), 64'd12);
    applyStimulus(0, 4'b0000, 4'b0010, 0, 0, 0);
    checkOutput("drain head 13", 64'(headWord(1)), 64'd13);
    applyStimulus(0, 4'b0000, 4'b0010, 0, 0, 0);
    checkOutput("drain head 14", 64'(headWord(1)), 64'd14);
    applyStimulus(0, 4'b0000, 4'b0010, 0, 0, 0);
    checkOutput("drain empty ch1", 64'(input_channel_empty_status[1]), 64'd1);

    // Wrap ch0's pointers with interleaved push/pop at occupancy 2.
    applyStimulus(0, 4'b0001, 4'b0000, 0, W'(100), 0);
    applyStimulus(0, 4'b0001, 4'b0000, 0, W'(101), 0);
    checkOutput("wrap prefill head", 64'(headWord(0)), 64'd100);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 4'b0001, 4'b0001, 0, W'(102 + k), 0);
      checkOutput($sformatf("wrap head k%0d", k), 64'(headWord(0)), 64'(101 + k));
      checkOutput($sformatf("wrap empty k%0d", k), 64'(input_channel_empty_status[0]), 64'd0);
    end
    applyStimulus(0, 4'b0001, 4'b0000, 0, W'(112), 0);
    checkOutput("three queued ready", 64'(input_channel_ready[0]), 64'd1);
    checkOutput("three queued head", 64'(headWord(0)), 64'd110);

    // Reset with data queued, and with a push and pop in the same cycle;
    // reset must dominate both.
    applyStimulus(1, 4'b0011, 4'b0001, 1, W'(55), 0);
    checkOutput("reset empty", 64'(input_channel_empty_status), 64'hF);
    checkOutput("reset ready", 64'(input_channel_ready), 64'hF);
    checkOutput("reset underflow", 64'(underflow_error), 64'd0);
    applyStimulus(0, 4'b0000, 4'b0000, 0, 0, 0);
    checkOutput("post reset idle empty", 64'(input_channel_empty_status), 64'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
